ce_est_buf: RTL

//  Ping-pong channel-estimate buffer directly downstream of the CE chain (LS->DCT->window->IDCT).

---
 rtl/ce_est_buf.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/ce_est_buf.sv
// Ping-pong channel-estimate buffer: captures clean IDCT frames into two banks and
// replays the oldest full bank to the equalizer with back-pressure via a 2-entry skid buffer.
`timescale 1ns / 1ps
module ce_est_buf #(
  parameter int unsigned wData = 16,
  parameter int unsigned DEPTH = 2048,
  parameter int unsigned wAddr = 11
) (
  input  logic             clk,
  input  logic             rst_n_sync,
  input  logic             sink_valid,
  output logic             sink_ready,
  input  logic [1:0]       sink_error,
  input  logic             sink_sop,
  input  logic             sink_eop,
  input  logic [wData-1:0] sink_real,
  input  logic [wData-1:0] sink_imag,
  input  logic [11:0]      fftpts_in,
  input  logic             play_req,
  input  logic             play_last,
  output logic             source_valid,
  input  logic             source_ready,
  output logic [1:0]       source_error,
  output logic             source_sop,
  output logic             source_eop,
  output logic [wData-1:0] source_real,
  output logic [wData-1:0] source_imag,
  output logic [11:0]      fftpts_out,
  output logic [1:0]       bank_full,
  output logic             play_busy,
  output logic             drop_err,
  output logic             underrun_err
);

  typedef enum logic [1:0] {WIdle, WFill, WDrop} w_state_e;
  typedef enum logic {RIdle, RPlay} r_state_e;

  localparam logic [wAddr-1:0] IdxZero = '0;

  // Write side state
  w_state_e         w_state_q;
  logic [wAddr-1:0] w_idx_q;
  logic [11:0]      w_len_q;
  logic             w_bad_q;
  logic             wr_bank_q;
  logic [1:0]       bank_full_q;
  logic [11:0]      bank_len_q [2];
  logic             sink_ready_q;
  logic             drop_err_q;

  // Read side state
  r_state_e         r_state_q;
  logic             rd_bank_q;
  logic             r_last_q;
  logic [11:0]      r_len_q;
  logic [11:0]      r_issue_q;
  logic [wAddr-1:0] r_out_q;
  logic             underrun_q;

  // Storage and skid buffer
  logic [2*wData-1:0] mem [2*DEPTH];
  logic [2*wData-1:0] rd_data_q;
  logic               ram_vld_q;
  logic [2*wData-1:0] skid_q [2];
  logic               skid_wr_q;
  logic               skid_rd_q;
  logic [1:0]         skid_cnt_q;

  // Combinational decode
  logic             w_acc, w_restart, beat_live, beat_end, beat_bad;
  logic             complete, frame_drop, abort;
  logic [wAddr-1:0] beat_idx;
  logic [11:0]      beat_len;
  logic [wAddr:0]   wr_addr, rd_addr;
  logic             any_full, oldest, r_start, pop, r_last_beat, r_done, issue_run, rd_en;
  logic [2:0]       occ;
  logic [1:0]       set_mask, clr_mask, bank_full_d;
  logic             wr_bank_d, busy_d, rd_bank_d, ready_d;

  always_comb begin
    w_acc      = sink_valid & sink_ready_q;
    w_restart  = sink_sop & (w_state_q != WDrop);
    beat_idx   = w_restart ? IdxZero : w_idx_q;
    beat_len   = w_restart ? fftpts_in : w_len_q;
    beat_bad   = (w_bad_q & ~w_restart) | (|sink_error);
    beat_live  = w_acc & (w_restart | (w_state_q == WFill));
    beat_end   = (12'(beat_idx) == beat_len - 12'd1);
    complete   = beat_live & sink_eop & beat_end & ~beat_bad;
    frame_drop = beat_live & (sink_eop ? ~(beat_end & ~beat_bad) : beat_end);
    abort      = w_acc & sink_sop & (w_state_q == WFill);
    wr_addr    = {wr_bank_q, beat_idx};

    any_full    = |bank_full_q;
    // With both banks full, the write pointer has wrapped onto the older one.
    oldest      = (&bank_full_q) ? wr_bank_q : bank_full_q[1];
    r_start     = (r_state_q == RIdle) & play_req & any_full;
    source_valid = (skid_cnt_q != 2'd0);
    pop         = source_valid & source_ready;
    r_last_beat = (12'(r_out_q) == r_len_q - 12'd1);
    r_done      = (r_state_q == RPlay) & pop & r_last_beat;
    occ         = 3'(skid_cnt_q) + 3'(ram_vld_q);
    // Issue only when the skid buffer can absorb every read already in flight.
    issue_run   = (r_state_q == RPlay) & (r_issue_q != r_len_q) & (occ < 3'd2 + 3'(pop));
    rd_en       = r_start | issue_run;
    rd_addr     = r_start ? {oldest, IdxZero} : {rd_bank_q, r_issue_q[wAddr-1:0]};

    set_mask    = complete ? (2'b01 << wr_bank_q) : 2'b00;
    clr_mask    = (r_done & r_last_q) ? (2'b01 << rd_bank_q) : 2'b00;
    bank_full_d = (bank_full_q | set_mask) & ~clr_mask;
    wr_bank_d   = wr_bank_q ^ complete;
    busy_d      = r_start | ((r_state_q == RPlay) & ~r_done);
    rd_bank_d   = r_start ? oldest : rd_bank_q;
    ready_d     = ~bank_full_d[wr_bank_d] & ~(busy_d & (rd_bank_d == wr_bank_d));
  end

  // Write FSM
  always_ff @(posedge clk or negedge rst_n_sync) begin
    if (!rst_n_sync) begin
      w_state_q     <= WIdle;
      w_idx_q       <= '0;
      w_len_q       <= '0;
      w_bad_q       <= 1'b0;
      wr_bank_q     <= 1'b0;
      bank_full_q   <= 2'b00;
      bank_len_q[0] <= '0;
      bank_len_q[1] <= '0;
      sink_ready_q  <= 1'b0;
      drop_err_q    <= 1'b0;
    end else begin
      drop_err_q   <= frame_drop | abort;
      sink_ready_q <= ready_d;
      wr_bank_q    <= wr_bank_d;
      bank_full_q  <= bank_full_d;
      if (complete) bank_len_q[wr_bank_q] <= beat_len;
      if (beat_live) begin
        w_len_q <= beat_len;
        w_bad_q <= beat_bad;
        w_idx_q <= beat_idx + wAddr'(1);
        if (sink_eop)      w_state_q <= WIdle;
        else if (beat_end) w_state_q <= WDrop;
        else               w_state_q <= WFill;
      end else if (w_acc && (w_state_q == WDrop) && sink_eop) begin
        w_state_q <= WIdle;
      end
    end
  end

  // Read FSM
  always_ff @(posedge clk or negedge rst_n_sync) begin
    if (!rst_n_sync) begin
      r_state_q  <= RIdle;
      rd_bank_q  <= 1'b0;
      r_last_q   <= 1'b0;
      r_len_q    <= '0;
      r_issue_q  <= '0;
      r_out_q    <= '0;
      underrun_q <= 1'b0;
    end else begin
      underrun_q <= (r_state_q == RIdle) & play_req & ~any_full;
      if (issue_run) r_issue_q <= r_issue_q + 12'd1;
      if (pop)       r_out_q   <= r_out_q + wAddr'(1);
      unique case (r_state_q)
        RIdle: begin
          if (r_start) begin
            rd_bank_q <= oldest;
            r_last_q  <= play_last;
            r_len_q   <= bank_len_q[oldest];
            r_issue_q <= 12'd1;
            r_out_q   <= '0;
            r_state_q <= RPlay;
          end
        end
        RPlay: begin
          if (r_done) r_state_q <= RIdle;
        end
        default: r_state_q <= RIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (beat_live) mem[wr_addr] <= {sink_real, sink_imag};
    if (rd_en)     rd_data_q    <= mem[rd_addr];
  end

  always_ff @(posedge clk or negedge rst_n_sync) begin
    if (!rst_n_sync) begin
      ram_vld_q  <= 1'b0;
      skid_q[0]  <= '0;
      skid_q[1]  <= '0;
      skid_wr_q  <= 1'b0;
      skid_rd_q  <= 1'b0;
      skid_cnt_q <= 2'd0;
    end else begin
      ram_vld_q <= rd_en;
      if (ram_vld_q) begin
        skid_q[skid_wr_q] <= rd_data_q;
        skid_wr_q         <= ~skid_wr_q;
      end
      if (pop) skid_rd_q <= ~skid_rd_q;
      skid_cnt_q <= skid_cnt_q + 2'(ram_vld_q) - 2'(pop);
    end
  end

  assign sink_ready   = sink_ready_q;
  assign source_error = 2'b00;
  assign source_sop   = source_valid & (r_out_q == IdxZero);
  assign source_eop   = source_valid & r_last_beat;
  assign source_real  = skid_q[skid_rd_q][2*wData-1:wData];
  assign source_imag  = skid_q[skid_rd_q][wData-1:0];
  assign fftpts_out   = r_len_q;
  assign bank_full    = bank_full_q;
  assign play_busy    = (r_state_q == RPlay);
  assign drop_err     = drop_err_q;
  assign underrun_err = underrun_q;

endmodule
